// File: rtl/univ_shift_reg.sv
// Universal shift register: load, SHL/SHR/ROL/ROR/ASR single step or shift-by-N; results visible one cycle after the edge.
// No backpressure: inputs are ignored while busy. Optional q_parity output under SHREG_PARITY_EN.
module univ_shift_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [2:0]            op,
    input  logic                  step_en,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic                  d_in,
    output logic [DATA_WIDTH-1:0] q_out,
    output logic                  ser_out,
    output logic                  busy,
`ifdef SHREG_PARITY_EN
    output logic                  q_parity,
`endif
    output logic                  done
);

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_ROL = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [2:0]             op_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [2:0]             step_op;
    logic [DATA_WIDTH-1:0]  step_q;
    logic                   step_ser;
    logic [DATA_WIDTH-1:0]  q_nxt;
    logic                   ser_nxt;

    // One step of the selected op; reserved codes leave q and ser_out untouched.
    always_comb begin
        step_op  = (state == SHIFT) ? op_q : op;
        step_q   = q_out;
        step_ser = ser_out;
        case (step_op)
            OP_SHL: begin step_q = {q_out[DATA_WIDTH-2:0], d_in};             step_ser = q_out[DATA_WIDTH-1]; end
            OP_SHR: begin step_q = {d_in, q_out[DATA_WIDTH-1:1]};             step_ser = q_out[0];            end
            OP_ROL: begin step_q = {q_out[DATA_WIDTH-2:0], q_out[DATA_WIDTH-1]}; step_ser = q_out[DATA_WIDTH-1]; end
            OP_ROR: begin step_q = {q_out[0], q_out[DATA_WIDTH-1:1]};         step_ser = q_out[0];            end
            OP_ASR: begin step_q = {q_out[DATA_WIDTH-1], q_out[DATA_WIDTH-1:1]}; step_ser = q_out[0];         end
            default: begin step_q = q_out; step_ser = ser_out; end
        endcase
    end

    // Any start in IDLE consumes the cycle, so step_en only acts when start is low.
    always_comb begin
        q_nxt   = q_out;
        ser_nxt = ser_out;
        if (state == SHIFT) begin
            q_nxt   = step_q;
            ser_nxt = step_ser;
        end else if (load_en) begin
            q_nxt   = load_data;
            ser_nxt = 1'b0;
        end else if (!start && step_en) begin
            q_nxt   = step_q;
            ser_nxt = step_ser;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= OP_SHL;
            cnt_q   <= '0;
            q_out   <= '0;
            ser_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SHREG_PARITY_EN
            q_parity <= 1'b0;
`endif
        end else begin
            q_out   <= q_nxt;
            ser_out <= ser_nxt;
            done    <= 1'b0;
`ifdef SHREG_PARITY_EN
            q_parity <= ^q_nxt;
`endif
            case (state)
                IDLE: begin
                    if (!load_en && start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else if (op <= OP_ASR) begin
                            op_q  <= op;
                            cnt_q <= count;
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt_q == CNT_WIDTH'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed vector table, reset-abort sequence, then random traffic against an arithmetic model.
module tb_univ_shift_reg;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_en;
    logic [W-1:0] load_data;
    logic [2:0]   op;
    logic         step_en;
    logic         start;
    logic [C-1:0] count;
    logic         d_in;
    logic [W-1:0] q_out;
    logic         ser_out;
    logic         busy;
    logic         done;
`ifdef SHREG_PARITY_EN
    logic         q_parity;
`endif

    int checks = 0;
    int errors = 0;

    univ_shift_reg #(.DATA_WIDTH(W), .CNT_WIDTH(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .load_data (load_data),
        .op        (op),
        .step_en   (step_en),
        .start     (start),
        .count     (count),
        .d_in      (d_in),
        .q_out     (q_out),
        .ser_out   (ser_out),
        .busy      (busy),
`ifdef SHREG_PARITY_EN
        .q_parity  (q_parity),
`endif
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference model: register value as an integer, shifts as multiply/divide.
    int unsigned m_q;
    int unsigned m_ser;
    int unsigned m_busy;
    int unsigned m_done;
    int unsigned m_rem;
    int unsigned m_op;

    function automatic void model_shift(input int unsigned o, input int unsigned d);
        int unsigned old;
        old = m_q;
        case (o)
            0: begin m_ser = old / 128; m_q = (old * 2) % 256 + d;              end
            1: begin m_ser = old % 2;   m_q = old / 2 + d * 128;                end
            2: begin m_ser = old / 128; m_q = (old * 2) % 256 + old / 128;      end
            3: begin m_ser = old % 2;   m_q = old / 2 + (old % 2) * 128;        end
            4: begin m_ser = old % 2;   m_q = old / 2 + (old / 128) * 128;      end
            default: ;
        endcase
    endfunction

    function automatic void model_edge();
        if (rst) begin
            m_q = 0; m_ser = 0; m_busy = 0; m_done = 0; m_rem = 0;
            return;
        end
        m_done = 0;
        if (m_busy != 0) begin
            model_shift(m_op, d_in);
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (load_en) begin
            m_q = load_data;
            m_ser = 0;
        end else if (start) begin
            if (count == 0) m_done = 1;
            else if (op <= 3'd4) begin
                m_op = op; m_rem = count; m_busy = 1;
            end
        end else if (step_en) begin
            model_shift(op, d_in);
        end
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic le, input logic [W-1:0] ld, input logic [2:0] o,
                         input logic se, input logic st, input logic [C-1:0] cn, input logic di);
        rst = r; load_en = le; load_data = ld; op = o; step_en = se; start = st; count = cn; d_in = di;
    endtask

    // Inputs are already stable; advance one edge, update the model, settle to the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input int unsigned eq, input int unsigned es,
                                 input int unsigned eb, input int unsigned ed);
        check({tag, " q_out"}, q_out, eq);
        check({tag, " ser_out"}, ser_out, es);
        check({tag, " busy"}, busy, eb);
        check({tag, " done"}, done, ed);
`ifdef SHREG_PARITY_EN
        check({tag, " q_parity"}, q_parity, $countones(eq[W-1:0]) % 2);
`endif
    endtask

    typedef struct {
        logic         rst;
        logic         load_en;
        logic [W-1:0] load_data;
        logic [2:0]   op;
        logic         step_en;
        logic         start;
        logic [C-1:0] count;
        logic         d_in;
        logic [W-1:0] exp_q;
        logic         exp_ser;
        logic         exp_busy;
        logic         exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, input logic le, input logic [W-1:0] ld, input logic [2:0] o,
                               input logic se, input logic st, input logic [C-1:0] cn, input logic di,
                               input logic [W-1:0] eq, input logic es, input logic eb, input logic ed);
        vec_t t;
        t.rst = r; t.load_en = le; t.load_data = ld; t.op = o; t.step_en = se; t.start = st;
        t.count = cn; t.d_in = di; t.exp_q = eq; t.exp_ser = es; t.exp_busy = eb; t.exp_done = ed;
        return t;
    endfunction

    initial begin
        m_q = 0; m_ser = 0; m_busy = 0; m_done = 0; m_rem = 0; m_op = 0;
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        //         rst ld  ldat   op    stp st cnt din   q     ser bsy dn
        vecs.push_back(v(1, 1, 8'hAA, 3'd0, 1, 1, 3, 1, 8'h00, 0, 0, 0));
        vecs.push_back(v(1, 0, 8'h55, 3'd3, 1, 1, 7, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 8'hB4, 3'd0, 0, 0, 0, 0, 8'hB4, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 1, 0, 0, 1, 8'h69, 1, 0, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd1, 1, 0, 0, 0, 8'h34, 1, 0, 0));
        vecs.push_back(v(0, 1, 8'h81, 3'd0, 0, 0, 0, 0, 8'h81, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd3, 0, 1, 3, 0, 8'h81, 0, 1, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 1, 0, 0, 0, 8'hC0, 1, 1, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 1, 1, 2, 1, 8'h60, 0, 1, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 0, 0, 0, 0, 8'h30, 0, 0, 1));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 0, 0, 0, 0, 8'h30, 0, 0, 0));
        vecs.push_back(v(0, 1, 8'h90, 3'd0, 0, 0, 0, 0, 8'h90, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd4, 0, 1, 2, 0, 8'h90, 0, 1, 0));
        vecs.push_back(v(0, 1, 8'hFF, 3'd4, 0, 0, 0, 0, 8'hC8, 0, 1, 0));
        vecs.push_back(v(0, 1, 8'hFF, 3'd4, 0, 0, 0, 0, 8'hE4, 0, 0, 1));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 0, 0, 0, 0, 8'hE4, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 0, 1, 0, 1, 8'hE4, 0, 0, 1));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 0, 0, 0, 0, 8'hE4, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd6, 0, 1, 4, 0, 8'hE4, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 0, 0, 0, 0, 8'hE4, 0, 0, 0));
        vecs.push_back(v(0, 1, 8'h0F, 3'd0, 0, 0, 0, 0, 8'h0F, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd2, 0, 1, 1, 0, 8'h0F, 0, 1, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 0, 1, 1, 1, 8'h1E, 0, 0, 1));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 0, 1, 1, 1, 8'h1E, 0, 1, 0));
        vecs.push_back(v(0, 0, 8'h00, 3'd0, 0, 0, 0, 1, 8'h3D, 0, 0, 1));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].load_en, vecs[i].load_data, vecs[i].op,
                  vecs[i].step_en, vecs[i].start, vecs[i].count, vecs[i].d_in);
            tick();
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_ser,
                          vecs[i].exp_busy, vecs[i].exp_done);
        end

        // Reset two steps into a five-step SHL: abort without done, then a fresh start.
        drive(0, 1, 8'hFF, 3'd0, 0, 0, 0, 0); tick(); check_outputs("abort load", 8'hFF, 0, 0, 0);
        drive(0, 0, 8'h00, 3'd0, 0, 1, 5, 0); tick(); check_outputs("abort start", 8'hFF, 0, 1, 0);
        drive(0, 0, 8'h00, 3'd0, 0, 0, 0, 0); tick(); check_outputs("abort step1", 8'hFE, 1, 1, 0);
        tick();                                       check_outputs("abort step2", 8'hFC, 1, 1, 0);
        drive(1, 0, 8'h00, 3'd0, 0, 0, 0, 0); tick(); check_outputs("abort rst", 8'h00, 0, 0, 0);
        drive(0, 0, 8'h00, 3'd0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_outputs("abort quiet", 8'h00, 0, 0, 0);
        end
        drive(0, 0, 8'h00, 3'd0, 0, 1, 1, 1); tick(); check_outputs("restart", 8'h00, 0, 1, 0);
        drive(0, 0, 8'h00, 3'd0, 0, 0, 0, 1); tick(); check_outputs("restart done", 8'h01, 0, 0, 1);

        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0), W'($urandom),
                  3'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), C'($urandom), 1'($urandom));
            tick();
            check_outputs($sformatf("rand%0d", i), m_q, m_ser, m_busy, m_done);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
